// File: rtl/sensor_deser_pkg.sv
// Shared types and constants for the multi-channel serial sensor deserialiser.
// Build option: define SENSOR_DESER_PARITY_EN to add a per-channel even-parity bit to each frame.
package sensor_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;
    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 8;

    // Counter holds 0..DATA_W+1, so it needs room for DATA_W+2 distinct values.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/sensor_deser_chan.sv
// One serial channel: shift register plus running even parity (parity only with SENSOR_DESER_PARITY_EN).
// o_word is the word a completing sample would produce this cycle.
module sensor_deser_chan #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_word
`ifdef SENSOR_DESER_PARITY_EN
    ,
    output logic              o_par
`endif
);

    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_word_next;

    // A start bit restarts from an empty register so a partial frame never leaks in.
    assign w_base = i_start ? '0 : r_sr;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_word_next = {w_base[DATA_W-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_word_next = {i_bit, w_base[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_start || i_shift) begin
            r_sr <= w_word_next;
        end
    end

`ifdef SENSOR_DESER_PARITY_EN
    logic r_par;
    logic w_par_next;

    assign w_par_next = (i_start ? 1'b0 : r_par) ^ i_bit;
    assign o_par      = w_par_next;
    // The parity bit is not shifted in, so the completed word is the register itself.
    assign o_word     = r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (i_start || i_shift) begin
            r_par <= w_par_next;
        end
    end
`else
    assign o_word = w_word_next;
`endif

endmodule

// File: rtl/sensor_deser.sv
// Multi-channel serial sensor deserialiser with valid/ready output and sticky overrun/sync flags.
// Build option: define SENSOR_DESER_PARITY_EN to enable the PARITY state and parity_err reporting.
module sensor_deser
    import sensor_deser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        sensor_in,
    input  logic                     sample_en,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] data,
    output logic                     valid,
    input  logic                     ready,
    output logic [NUM_CH-1:0]        parity_err,
    output logic                     overrun,
    output logic                     sync_err,
    input  logic                     status_clr
);

    localparam int                CNT_W     = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

    generate
        if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
            NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_param_check
            $error("sensor_deser: DATA_W or NUM_CH out of range");
        end
    endgenerate

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_count;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic                     r_valid;
    logic [NUM_CH-1:0]        r_perr;
    logic                     r_ovr;
    logic                     r_sync;

    logic                     w_start;
    logic                     w_bit_only;
    logic                     w_chan_shift;
    logic                     w_complete;
    logic                     w_sync_abort;
    logic                     w_load;
    logic                     w_drop;
    logic [NUM_CH*DATA_W-1:0] w_new_data;
    logic [NUM_CH-1:0]        w_new_perr;

    assign w_start    = sample_en & frame_sync;
    assign w_bit_only = sample_en & ~frame_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_count <= CNT_W'(1);
            end else if (w_complete) begin
                r_count <= '0;
            end else if (w_bit_only && r_state != ST_IDLE) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end else if (w_bit_only && r_count == LAST_DATA) begin
`ifdef SENSOR_DESER_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
            ST_PARITY: begin
`ifdef SENSOR_DESER_PARITY_EN
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end else if (w_bit_only) begin
                    w_state_next = ST_IDLE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_chan_shift = 1'b0;
        w_complete   = 1'b0;
        w_sync_abort = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                w_chan_shift = w_bit_only;
                w_sync_abort = w_start;
`ifndef SENSOR_DESER_PARITY_EN
                w_complete   = w_bit_only && (r_count == LAST_DATA);
`endif
            end
            ST_PARITY: begin
                w_sync_abort = w_start;
`ifdef SENSOR_DESER_PARITY_EN
                w_complete   = w_bit_only;
`endif
            end
            default: ;
        endcase
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
            sensor_deser_chan #(
                .DATA_W    (DATA_W),
                .MSB_FIRST (MSB_FIRST)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .i_start (w_start),
                .i_shift (w_chan_shift),
                .i_bit   (sensor_in[c]),
                .o_word  (w_new_data[c*DATA_W +: DATA_W])
`ifdef SENSOR_DESER_PARITY_EN
                ,
                .o_par   (w_new_perr[c])
`endif
            );
        end
    endgenerate

`ifndef SENSOR_DESER_PARITY_EN
    assign w_new_perr = '0;
`endif

    // A finished word only lands if the output slot is free or being emptied this cycle.
    assign w_load = w_complete & (~r_valid | ready);
    assign w_drop = w_complete & r_valid & ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= '0;
        end else if (w_load) begin
            r_data  <= w_new_data;
            r_valid <= 1'b1;
            r_perr  <= w_new_perr;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    // Setting events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr  <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            if (w_drop)            r_ovr <= 1'b1;
            else if (status_clr)   r_ovr <= 1'b0;
            if (w_sync_abort)      r_sync <= 1'b1;
            else if (status_clr)   r_sync <= 1'b0;
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;
    assign sync_err   = r_sync;

endmodule

// File: tb/tb_sensor_deser.sv
// Scoreboard bench for sensor_deser: frame-level reference model feeds an expected-word queue,
// a negedge monitor pops and compares on every accepted word and checks valid/flags each cycle.
module tb_sensor_deser;

    localparam int DATA_W    = 8;
    localparam int NUM_CH    = 2;
    localparam int MSB_FIRST = 1;
    localparam int W         = NUM_CH * DATA_W;
`ifdef SENSOR_DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] sensor_in;
    logic              sample_en;
    logic              frame_sync;
    logic [W-1:0]      data;
    logic              valid;
    logic              ready;
    logic [NUM_CH-1:0] parity_err;
    logic              overrun;
    logic              sync_err;
    logic              status_clr;

    sensor_deser #(
        .DATA_W    (DATA_W),
        .NUM_CH    (NUM_CH),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_in  (sensor_in),
        .sample_en  (sample_en),
        .frame_sync (frame_sync),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .overrun    (overrun),
        .sync_err   (sync_err),
        .status_clr (status_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]      d;
        logic [NUM_CH-1:0] p;
    } exp_t;

    exp_t              sb_q[$];
    logic [NUM_CH-1:0] m_bits[$];
    bit                m_in_frame = 1'b0;
    bit                m_valid    = 1'b0;
    bit                m_ovr      = 1'b0;
    bit                m_sync     = 1'b0;
    bit                chk_valid  = 1'b0;
    bit                chk_ovr    = 1'b0;
    bit                chk_sync   = 1'b0;
    bit                chk_en     = 1'b0;
    bit                g_rst      = 1'b1;
    bit                g_ready    = 1'b1;
    bit                g_clr      = 1'b0;
    bit                g_rand_rdy = 1'b0;
    int                n_checks   = 0;
    int                n_pass     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: collect bits of the current frame, assemble the word when it is full.
    task automatic model_edge(input logic se, input logic fs, input logic [NUM_CH-1:0] b);
        bit   accept, complete, sync_set, drop;
        exp_t e;
        if (g_rst) begin
            m_bits.delete();
            sb_q.delete();
            m_in_frame = 0; m_valid = 0; m_ovr = 0; m_sync = 0;
            return;
        end
        accept = m_valid && g_ready;
        complete = 0; sync_set = 0; drop = 0;
        if (se) begin
            if (fs) begin
                if (m_in_frame) sync_set = 1;
                m_bits.delete();
                m_bits.push_back(b);
                m_in_frame = 1;
            end else if (m_in_frame) begin
                m_bits.push_back(b);
                if (m_bits.size() == FRAME_LEN) begin
                    complete = 1;
                    m_in_frame = 0;
                end
            end
        end
        if (complete) begin
            e = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    if (i < DATA_W)
                        e.d[c*DATA_W + ((MSB_FIRST != 0) ? (DATA_W-1-i) : i)] = m_bits[i][c];
                    e.p[c] = e.p[c] ^ m_bits[i][c];
                end
            end
`ifndef SENSOR_DESER_PARITY_EN
            e.p = '0;
`endif
            if (!m_valid || g_ready) begin
                sb_q.push_back(e);
                m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (accept) begin
            m_valid = 0;
        end
        m_ovr  = drop     ? 1'b1 : (g_clr ? 1'b0 : m_ovr);
        m_sync = sync_set ? 1'b1 : (g_clr ? 1'b0 : m_sync);
    endtask

    task automatic step(input logic se, input logic fs, input logic [NUM_CH-1:0] b);
        @(posedge clk);
        #2;
        chk_valid = m_valid;
        chk_ovr   = m_ovr;
        chk_sync  = m_sync;
        if (g_rand_rdy) g_ready = ($urandom_range(0, 3) != 0);
        rst        = g_rst;
        ready      = g_ready;
        status_clr = g_clr;
        sample_en  = se;
        frame_sync = fs;
        sensor_in  = b;
        model_edge(se, fs, b);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), NUM_CH'($urandom));
    endtask

    task automatic send_bits(input logic [W-1:0] w, input logic [NUM_CH-1:0] pb, input int n, input int gap);
        logic [NUM_CH-1:0] b;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) idle();
            for (int c = 0; c < NUM_CH; c++)
                b[c] = (i < DATA_W) ? w[c*DATA_W + DATA_W-1-i] : pb[c];
            step(1'b1, (i == 0), b);
        end
    endtask

    function automatic logic [NUM_CH-1:0] even_par(input logic [W-1:0] w);
        logic [NUM_CH-1:0] p;
        for (int c = 0; c < NUM_CH; c++) p[c] = ^w[c*DATA_W +: DATA_W];
        return p;
    endfunction

    task automatic send_frame(input logic [W-1:0] w, input int gap);
        send_bits(w, even_par(w), FRAME_LEN, gap);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("valid", 32'(valid), 32'(chk_valid));
            check("overrun", 32'(overrun), 32'(chk_ovr));
            check("sync_err", 32'(sync_err), 32'(chk_sync));
            if (valid && ready && !rst) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", data);
                end else begin
                    e = sb_q.pop_front();
                    check("data", 32'(data), 32'(e.d));
                    check("parity_err", 32'(parity_err), 32'(e.p));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ready = 1'b1; status_clr = 1'b0;
        sample_en = 1'b0; frame_sync = 1'b0; sensor_in = '0;

        // Reset state
        g_rst = 1;
        idle();
        idle();
        chk_en = 1;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_flags", {30'h0, overrun, sync_err}, 32'h0);
        g_rst = 0;
        idle();

        // Back-to-back strobes
        send_frame(16'hFFA5, 0);
        idle();
        @(negedge clk);
        check("frame_ffa5", 32'(data), 32'h0000FFA5);
        check("frame_ffa5_valid", 32'(valid), 32'h1);
        idle();

        // Strobe every third cycle
        send_frame(16'hFFA5, 2);
        idle();
        @(negedge clk);
        check("slow_ffa5", 32'(data), 32'h0000FFA5);
        idle();

        // Overrun with a stalled consumer, then clear
        g_ready = 0;
        send_frame(16'h0011, 0);
        send_frame(16'h0022, 0);
        idle();
        idle();
        @(negedge clk);
        check("ovr_hold", 32'(data[7:0]), 32'h11);
        check("ovr_flag", 32'(overrun), 32'h1);
        g_clr = 1;
        idle();
        g_clr = 0;
        idle();
        @(negedge clk);
        check("ovr_clr", 32'(overrun), 32'h0);
        g_ready = 1;
        idle();
        idle();

        // Early frame_sync at bit 5
        send_bits(16'h00FF, '0, 5, 0);
        send_frame(16'h5A96, 0);
        idle();
        @(negedge clk);
        check("sync_flag", 32'(sync_err), 32'h1);
        check("sync_word", 32'(data), 32'h00005A96);
        g_clr = 1;
        idle();
        g_clr = 0;
        idle();

        // Reset mid-frame with a pending word
        g_ready = 0;
        send_frame(16'h7777, 0);
        send_bits(16'hFFFF, '0, 4, 0);
        g_rst = 1;
        idle();
        g_rst = 0;
        g_ready = 1;
        idle();
        @(negedge clk);
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_flags", {30'h0, overrun, sync_err}, 32'h0);
        send_frame(16'hC33C, 0);
        idle();
        @(negedge clk);
        check("after_rst_word", 32'(data), 32'h0000C33C);
        check("after_rst_flags", {30'h0, overrun, sync_err}, 32'h0);
        check("after_rst_perr", 32'(parity_err), 32'h0);
        idle();

`ifdef SENSOR_DESER_PARITY_EN
        // ch0 0xA5 and ch1 0x01, both with parity bit 0
        send_bits(16'h01A5, 2'b00, FRAME_LEN, 0);
        idle();
        @(negedge clk);
        check("parity_err", 32'(parity_err), 32'h2);
        idle();
`endif

        // Randomised traffic
        g_rand_rdy = 1;
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_bits(W'($urandom), NUM_CH'($urandom), $urandom_range(1, FRAME_LEN-1), $urandom_range(0, 1));
            end else if (r == 1) begin
                g_clr = 1;
                idle();
                g_clr = 0;
            end else if (r == 2) begin
                step(1'b1, 1'b0, NUM_CH'($urandom));
            end
            send_frame(W'($urandom), $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) idle();
        end
        g_rand_rdy = 0;
        g_ready = 1;
        repeat (4) idle();
        @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
